// File: rtl/icb_copy_master.sv
// ICB initiator that copies a block of 32-bit words from src to dst.
// Each word is one read followed by one write, with a single transaction in flight.
module icb_copy_master #(
  parameter int unsigned LEN_W        = 16,
  parameter bit          ABORT_ON_ERR = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [31:0]      src_addr_i,
  input  logic [31:0]      dst_addr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             m_icb_cmd_valid,
  input  logic             m_icb_cmd_ready,
  output logic [31:0]      m_icb_cmd_addr,
  output logic             m_icb_cmd_read,
  output logic [31:0]      m_icb_cmd_wdata,
  output logic [3:0]       m_icb_cmd_wmask,
  input  logic             m_icb_rsp_valid,
  output logic             m_icb_rsp_ready,
  input  logic             m_icb_rsp_err,
  input  logic [31:0]      m_icb_rsp_rdata
);

  typedef enum logic [2:0] {IDLE, RD_CMD, RD_RSP, WR_CMD, WR_RSP, DONE} state_e;

  localparam logic [LEN_W-1:0] CNT_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] CNT_ZERO = '0;

  state_e           state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [31:0]      data_q, data_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Bus outputs decode from state_q only, so an async reset drops them at once.
  always_comb begin
    state_d         = state_q;
    src_d           = src_q;
    dst_d           = dst_q;
    data_d          = data_q;
    cnt_d           = cnt_q;
    err_d           = err_q;
    m_icb_cmd_valid = 1'b0;
    m_icb_cmd_addr  = '0;
    m_icb_cmd_read  = 1'b0;
    m_icb_cmd_wdata = '0;
    m_icb_cmd_wmask = 4'h0;
    m_icb_rsp_ready = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          src_d   = {src_addr_i[31:2], 2'b00};
          dst_d   = {dst_addr_i[31:2], 2'b00};
          cnt_d   = len_i;
          err_d   = 1'b0;
          state_d = (len_i == CNT_ZERO) ? DONE : RD_CMD;
        end
      end
      RD_CMD: begin
        m_icb_cmd_valid = 1'b1;
        m_icb_cmd_read  = 1'b1;
        m_icb_cmd_addr  = src_q;
        if (m_icb_cmd_ready) state_d = RD_RSP;
      end
      RD_RSP: begin
        m_icb_rsp_ready = 1'b1;
        if (m_icb_rsp_valid) begin
          data_d  = m_icb_rsp_rdata;
          state_d = WR_CMD;
          if (m_icb_rsp_err) begin
            err_d = 1'b1;
            if (ABORT_ON_ERR) state_d = DONE;
          end
        end
      end
      WR_CMD: begin
        m_icb_cmd_valid = 1'b1;
        m_icb_cmd_addr  = dst_q;
        m_icb_cmd_wdata = data_q;
        m_icb_cmd_wmask = 4'hF;
        if (m_icb_cmd_ready) state_d = WR_RSP;
      end
      WR_RSP: begin
        m_icb_rsp_ready = 1'b1;
        if (m_icb_rsp_valid) begin
          if (m_icb_rsp_err) err_d = 1'b1;
          if ((m_icb_rsp_err && ABORT_ON_ERR) || (cnt_q == CNT_ONE)) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q - CNT_ONE;
            src_d   = src_q + 32'd4;
            dst_d   = dst_q + 32'd4;
            state_d = RD_CMD;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign done_o = (state_q == DONE);
  assign busy_o = (state_q != IDLE) && (state_q != DONE);
  assign err_o  = err_q;

endmodule

// File: tb/tb_icb_copy_master.sv
// Directed bench for icb_copy_master with a configurable ICB slave model.
module tb_icb_copy_master;

  logic        clk, rst_n, start_i;
  logic [31:0] src_addr_i, dst_addr_i;
  logic [15:0] len_i;
  logic        busy_o, done_o, err_o;
  logic        m_icb_cmd_valid, m_icb_cmd_ready, m_icb_cmd_read;
  logic [31:0] m_icb_cmd_addr, m_icb_cmd_wdata;
  logic [3:0]  m_icb_cmd_wmask;
  logic        m_icb_rsp_valid, m_icb_rsp_ready, m_icb_rsp_err;
  logic [31:0] m_icb_rsp_rdata;

  icb_copy_master #(.LEN_W(16), .ABORT_ON_ERR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i),
    .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .m_icb_cmd_valid(m_icb_cmd_valid), .m_icb_cmd_ready(m_icb_cmd_ready),
    .m_icb_cmd_addr(m_icb_cmd_addr), .m_icb_cmd_read(m_icb_cmd_read),
    .m_icb_cmd_wdata(m_icb_cmd_wdata), .m_icb_cmd_wmask(m_icb_cmd_wmask),
    .m_icb_rsp_valid(m_icb_rsp_valid), .m_icb_rsp_ready(m_icb_rsp_ready),
    .m_icb_rsp_err(m_icb_rsp_err), .m_icb_rsp_rdata(m_icb_rsp_rdata)
  );

  int vec_cnt = 0;
  int miscmp_cnt = 0;
  int cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Slave configuration and command log (one entry per command handshake).
  int          cfg_ready_wait = 0;
  int          cfg_rsp_delay  = 0;
  int          cfg_err_read   = 0;
  bit          cfg_block_wr   = 1'b0;
  int          rd_count       = 0;
  int          stab_err       = 0;
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  logic        log_read[$];
  logic [3:0]  log_mask[$];

  // Slave: decides at each negedge, so every handshake lands on the following posedge.
  // Read data for word address A is A ^ 32'hC0DE_0000.
  initial begin
    bit          cmd_hs, rsp_hs, pend, pend_err, hold_prev;
    int          rsp_wait, rdy_cnt;
    logic [31:0] c_addr, c_wdata, pend_data;
    logic        c_read;
    logic [3:0]  c_mask;
    cmd_hs = 0; rsp_hs = 0; pend = 0; pend_err = 0; hold_prev = 0;
    rsp_wait = 0; rdy_cnt = 0; pend_data = 0;
    c_addr = 0; c_wdata = 0; c_read = 0; c_mask = 0;
    m_icb_cmd_ready = 0; m_icb_rsp_valid = 0; m_icb_rsp_err = 0; m_icb_rsp_rdata = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cmd_hs = 0; rsp_hs = 0; pend = 0; hold_prev = 0; rdy_cnt = 0;
        m_icb_cmd_ready = 0; m_icb_rsp_valid = 0; m_icb_rsp_err = 0;
      end else begin
        if (rsp_hs) begin
          m_icb_rsp_valid = 0;
          m_icb_rsp_err   = 0;
        end
        if (cmd_hs) begin
          log_addr.push_back(c_addr); log_data.push_back(c_wdata);
          log_read.push_back(c_read); log_mask.push_back(c_mask);
          pend = 1; rsp_wait = cfg_rsp_delay;
          if (c_read) begin
            rd_count++;
            pend_err  = (rd_count == cfg_err_read);
            pend_data = c_addr ^ 32'hC0DE_0000;
          end else begin
            pend_err  = 0;
            pend_data = 32'h0;
          end
        end
        if (pend) begin
          if (rsp_wait == 0) begin
            m_icb_rsp_valid = 1; m_icb_rsp_err = pend_err; m_icb_rsp_rdata = pend_data;
            pend = 0;
          end else rsp_wait--;
        end
        if (hold_prev && (!m_icb_cmd_valid || m_icb_cmd_addr !== c_addr ||
            m_icb_cmd_read !== c_read || m_icb_cmd_wdata !== c_wdata ||
            m_icb_cmd_wmask !== c_mask)) stab_err++;
        if (m_icb_cmd_valid) begin
          m_icb_cmd_ready = (rdy_cnt >= cfg_ready_wait) && !(cfg_block_wr && !m_icb_cmd_read);
          rdy_cnt++;
        end else begin
          m_icb_cmd_ready = 0;
          rdy_cnt = 0;
        end
        c_addr = m_icb_cmd_addr; c_read = m_icb_cmd_read;
        c_wdata = m_icb_cmd_wdata; c_mask = m_icb_cmd_wmask;
        hold_prev = m_icb_cmd_valid && !m_icb_cmd_ready;
        cmd_hs    = m_icb_cmd_valid && m_icb_cmd_ready;
        rsp_hs    = m_icb_rsp_valid && m_icb_rsp_ready;
      end
    end
  end

  // Starts a copy with start in cycle 0 and returns the cycle in which done_o was seen.
  task automatic run(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] len,
                     input int rw, input int rd, input int er, input bit poke,
                     output int done_cyc, output int n_valid, output bit busy_seen);
    int t0;
    cfg_ready_wait = rw; cfg_rsp_delay = rd; cfg_err_read = er;
    log_addr.delete(); log_data.delete(); log_read.delete(); log_mask.delete();
    rd_count = 0;
    @(negedge clk);
    start_i = 1; src_addr_i = src; dst_addr_i = dst; len_i = len; t0 = cyc;
    @(negedge clk);
    start_i = 0;
    done_cyc = -1; n_valid = 0; busy_seen = 0;
    for (int i = 0; i < 2000 && done_cyc < 0; i++) begin
      if (busy_o) busy_seen = 1;
      if (m_icb_cmd_valid) n_valid++;
      if (done_o) done_cyc = cyc - t0;
      if (poke && i == 2) begin
        start_i = 1; len_i = 16'd9; src_addr_i = 32'hDEAD_0000;
      end else start_i = 0;
      if (done_cyc < 0) @(negedge clk);
    end
    start_i = 0;
    chk("done_reached", done_cyc >= 0, 1);
    @(negedge clk);
    chk("done_one_cycle", done_o, 0);
  endtask

  int dc, nv;
  bit bs;
  int done_seen;

  initial begin
    rst_n = 0; start_i = 0; src_addr_i = 0; dst_addr_i = 0; len_i = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_cmd_valid", m_icb_cmd_valid, 0);
    chk("rst_rsp_ready", m_icb_rsp_ready, 0);
    @(negedge clk);
    rst_n = 1;

    // Zero-wait 3-word copy.
    run(32'h100, 32'h200, 16'd3, 0, 0, 0, 1'b0, dc, nv, bs);
    $display("copy3: done cycle %0d, %0d commands", dc, log_addr.size());
    chk("c3_done_cyc", dc, 13);
    chk("c3_ncmd", log_addr.size(), 6);
    chk("c3_rd0_addr", log_addr[0], 32'h100);
    chk("c3_rd0_read", log_read[0], 1);
    chk("c3_rd0_mask", log_mask[0], 4'h0);
    chk("c3_wr0_addr", log_addr[1], 32'h200);
    chk("c3_wr0_read", log_read[1], 0);
    chk("c3_wr0_data", log_data[1], 32'hC0DE_0100);
    chk("c3_wr0_mask", log_mask[1], 4'hF);
    chk("c3_wr1_addr", log_addr[3], 32'h204);
    chk("c3_wr1_data", log_data[3], 32'hC0DE_0104);
    chk("c3_wr2_addr", log_addr[5], 32'h208);
    chk("c3_wr2_data", log_data[5], 32'hC0DE_0108);
    chk("c3_err", err_o, 0);

    // Zero-length start.
    run(32'h100, 32'h200, 16'd0, 0, 0, 0, 1'b0, dc, nv, bs);
    $display("len0: done cycle %0d, valid cycles %0d", dc, nv);
    chk("l0_done_cyc", dc, 1);
    chk("l0_valid_cycles", nv, 0);
    chk("l0_busy_seen", bs, 0);

    // Slow slave: ready after 5 cycles, response 3 cycles late.
    stab_err = 0;
    run(32'h300, 32'h400, 16'd2, 5, 3, 0, 1'b0, dc, nv, bs);
    $display("slow2: done cycle %0d, %0d commands", dc, log_addr.size());
    chk("sl_ncmd", log_addr.size(), 4);
    chk("sl_stable", stab_err, 0);
    chk("sl_wr0_data", log_data[1], 32'hC0DE_0300);
    chk("sl_wr1_addr", log_addr[3], 32'h404);
    chk("sl_wr1_data", log_data[3], 32'hC0DE_0304);

    // Error on second read aborts.
    run(32'h500, 32'h600, 16'd4, 0, 0, 2, 1'b0, dc, nv, bs);
    $display("err: done cycle %0d, %0d commands", dc, log_addr.size());
    chk("er_ncmd", log_addr.size(), 3);
    chk("er_wr_addr", log_addr[1], 32'h600);
    chk("er_rd1_addr", log_addr[2], 32'h504);
    chk("er_err", err_o, 1);
    run(32'h520, 32'h620, 16'd1, 0, 0, 0, 1'b0, dc, nv, bs);
    $display("after err: done cycle %0d", dc);
    chk("er_cleared", err_o, 0);
    chk("er_next_data", log_data[1], 32'hC0DE_0520);

    // Address wrap and low-bit masking.
    run(32'hFFFF_FFFC, 32'h700, 16'd2, 0, 0, 0, 1'b0, dc, nv, bs);
    $display("wrap: done cycle %0d", dc);
    chk("wr_rd0_addr", log_addr[0], 32'hFFFF_FFFC);
    chk("wr_wr0_data", log_data[1], 32'h3F21_FFFC);
    chk("wr_rd1_addr", log_addr[2], 32'h0000_0000);
    chk("wr_wr1_data", log_data[3], 32'hC0DE_0000);
    run(32'h103, 32'h207, 16'd1, 0, 0, 0, 1'b0, dc, nv, bs);
    $display("align: done cycle %0d", dc);
    chk("al_rd_addr", log_addr[0], 32'h100);
    chk("al_wr_addr", log_addr[1], 32'h204);

    // start_i while busy is ignored.
    run(32'h800, 32'h900, 16'd2, 0, 0, 0, 1'b1, dc, nv, bs);
    $display("poke: done cycle %0d, %0d commands", dc, log_addr.size());
    chk("pk_done_cyc", dc, 9);
    chk("pk_ncmd", log_addr.size(), 4);
    chk("pk_wr1_addr", log_addr[3], 32'h904);

    // Reset while a write command is stalled.
    cfg_block_wr = 1; cfg_ready_wait = 0; cfg_rsp_delay = 0; cfg_err_read = 0;
    @(negedge clk);
    start_i = 1; src_addr_i = 32'hA00; dst_addr_i = 32'hB00; len_i = 16'd1;
    @(negedge clk);
    start_i = 0;
    for (int i = 0; i < 50 && !(m_icb_cmd_valid && !m_icb_cmd_read); i++) @(negedge clk);
    chk("rs_wr_addr", m_icb_cmd_addr, 32'hB00);
    chk("rs_wr_data", m_icb_cmd_wdata, 32'hC0DE_0A00);
    #2 rst_n = 0;
    #1;
    $display("reset mid-write: cmd_valid %0b busy %0b", m_icb_cmd_valid, busy_o);
    chk("rs_valid_drop", m_icb_cmd_valid, 0);
    chk("rs_busy_drop", busy_o, 0);
    chk("rs_rsp_ready", m_icb_rsp_ready, 0);
    repeat (3) @(negedge clk);
    rst_n = 1; cfg_block_wr = 0;
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done_o) done_seen++;
    end
    chk("rs_no_done", done_seen, 0);
    chk("rs_idle_valid", m_icb_cmd_valid, 0);
    chk("rs_idle_busy", busy_o, 0);
    chk("rs_idle_err", err_o, 0);
    chk("rs_idle_addr", m_icb_cmd_addr, 32'h0);
    chk("rs_idle_wmask", m_icb_cmd_wmask, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule

// File: doc/icb_copy_master.md
Name: icb_copy_master

Overview:
- ICB initiator that copies a block of 32-bit words from a source address to a destination address. It issues a read, then a write, per word, with one outstanding transaction at a time.
- It sits beside the core on the ICB fabric. It drives ICB slaves such as the instruction RAM's ICB port, for example when the ISP stage moves an image into user instruction space.
- A simple start/busy/done/err control interface faces a controller: ISP logic or a CSR block.

Parameters:
- LEN_W, 16, width of the word-count input; maximum transfer is 2^LEN_W-1 words.
- ABORT_ON_ERR, 1, 1 = stop at the first rsp_err; 0 = record the error and continue the copy.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start_i  input  1  single-cycle start request; sampled only in IDLE
- src_addr_i  input  32  source byte address; bits [1:0] ignored (forced 0)
- dst_addr_i  input  32  destination byte address; bits [1:0] ignored (forced 0)
- len_i  input  LEN_W  number of words to copy
- busy_o  output  1  high from the cycle after an accepted start until DONE
- done_o  output  1  one-cycle completion pulse
- err_o  output  1  sticky: some response had rsp_err; cleared by the next accepted start
- m_icb_cmd_valid  output  1  command valid
- m_icb_cmd_ready  input  1  command accepted by slave
- m_icb_cmd_addr  output  32  command byte address (word aligned)
- m_icb_cmd_read  output  1  1 = read, 0 = write
- m_icb_cmd_wdata  output  32  write data
- m_icb_cmd_wmask  output  4  write byte strobes
- m_icb_rsp_valid  input  1  response valid
- m_icb_rsp_ready  output  1  response accepted
- m_icb_rsp_err  input  1  response error
- m_icb_rsp_rdata  input  32  read data

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0; FSM in IDLE; internal address, count and data registers 0.
- Reset asserted mid-transfer: abandon immediately, drop cmd_valid and rsp_ready asynchronously. No done pulse afterwards.
- FSM states: IDLE, RD_CMD, RD_RSP, WR_CMD, WR_RSP, DONE.
- IDLE:
  - start_i=1: latch {src[31:2],2'b00}, {dst[31:2],2'b00} and len_i; clear err_o.
  - If len_i != 0, go to RD_CMD; if len_i == 0, go to DONE (no bus traffic).
  - start_i outside IDLE is ignored.
- RD_CMD:
  - Drive cmd_valid=1, cmd_read=1, cmd_addr=src_ptr.
  - Hold valid and all command fields stable until cmd_ready=1; the handshake cycle moves to RD_RSP.
- RD_RSP:
  - Drive rsp_ready=1.
  - On rsp_valid: capture rsp_rdata into the data register.
  - If rsp_err: set err_o. With ABORT_ON_ERR=1 go to DONE; otherwise continue to WR_CMD with the captured data.
  - With no error, go to WR_CMD.
- WR_CMD:
  - Drive cmd_valid=1, cmd_read=0, cmd_addr=dst_ptr, cmd_wdata=data register, cmd_wmask=4'hF.
  - Hold until cmd_ready, then go to WR_RSP.
- WR_RSP:
  - Drive rsp_ready=1.
  - On rsp_valid: if rsp_err, set err_o (with ABORT_ON_ERR=1 go to DONE).
  - Otherwise, if count==1, go to DONE. Else count-=1, src_ptr+=4, dst_ptr+=4 (32-bit modulo wrap, 0xFFFF_FFFC -> 0x0000_0000), and go to RD_CMD.
- DONE: done_o=1 for exactly one cycle, busy_o=0, then IDLE.
- Handshake rules:
  - rsp_ready is 0 outside RD_RSP/WR_RSP. cmd_valid is 0 outside RD_CMD/WR_CMD.
  - Responses arriving in the cmd-handshake cycle are not consumed. Slaves on this fabric register rsp_valid and respond one or more cycles after the command.
  - cmd_valid never de-asserts before cmd_ready.
  - cmd_wmask is 4'h0 during reads.
- Latency: with a zero-wait slave (cmd_ready=1, rsp_valid one cycle after cmd), each word takes 4 cycles. An N-word copy with the start in cycle 0 spends cycles 1..4N in transfer, and done_o is high in cycle 4N+1.
- busy_o = (state != IDLE && state != DONE).

Test Plan:
- Zero-wait slave model; src=0x0000_0100, dst=0x0000_0200, len=3, memory[0x100..0x108]={A,B,C}:
  - writes to 0x200, 0x204, 0x208 with data A, B, C and wmask F;
  - done_o high in cycle 13; err_o=0.
- len=0 start -> no cmd_valid ever; done_o pulses in cycle 1; busy_o stays 0.
- Slave with cmd_ready held low 5 cycles and rsp_valid delayed 3 cycles, len=2 -> addr/read/wdata stable while waiting; exactly 4 command handshakes; data copied correctly.
- rsp_err on the second read, ABORT_ON_ERR=1, len=4 -> one write only (to dst), then done_o with err_o=1. The next start with a good slave clears err_o.
- src=0xFFFF_FFFC, len=2 -> second read address is 0x0000_0000; src_addr_i=0x103 is issued as 0x100.
- start_i pulsed while busy -> ignored, current transfer unaffected. rst_n low mid-WR_CMD -> cmd_valid drops immediately; after release the block is in IDLE with all outputs 0.
